// File: rtl/suma_serie_nbits.sv
// Multi-cycle N-bit adder/subtractor. Each cycle a DIGIT-wide ripple of
// full-adder cells consumes one slice of the operands, LSB slice first, with
// the carry held in a register between slices.
//
// state | meaning
// IDLE  | waiting for start; last result held on So/Co/Ov
// RUN   | one slice per clock, counter selects the slice
module suma_serie_nbits #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] So,
    output logic             Co,
    output logic             Ov
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("suma_serie_nbits: DIGIT must divide WIDTH exactly");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("suma_serie_nbits: WIDTH must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             accept, last;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic [WIDTH-1:0] so_q;
    logic             co_q, ov_q, done_q;

    logic [DIGIT-1:0] a_sl, b_sl, s_sl;
    logic [DIGIT:0]   c_ch;
    logic [WIDTH-1:0] acc_d;
    int               slice_base;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; start is only looked at in IDLE, so it is ignored while busy.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slice ripple: DIGIT full-adder cells fed from the carry register.
    // c_ch[DIGIT-1] is the carry into the MSB cell of the slice, which on the
    // final slice is the carry into the operand MSB used for overflow.
    always_comb begin
        slice_base = int'(cnt_q) * DIGIT;
        a_sl       = a_q[slice_base +: DIGIT];
        b_sl       = b_q[slice_base +: DIGIT];
        c_ch       = '0;
        s_sl       = '0;
        c_ch[0]    = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            s_sl[i]   = a_sl[i] ^ b_sl[i] ^ c_ch[i];
            c_ch[i+1] = (a_sl[i] & b_sl[i]) | (c_ch[i] & (a_sl[i] ^ b_sl[i]));
        end
        acc_d                         = acc_q;
        acc_d[slice_base +: DIGIT]    = s_sl;
    end

    // Operand capture on accept, slice accumulation while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= Op ? ~B : B;
            carry_q <= Op ? 1'b1 : Ci;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            acc_q   <= acc_d;
            carry_q <= c_ch[DIGIT];
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    // Result registers only change on the final slice, so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so_q   <= '0;
            co_q   <= 1'b0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                so_q <= acc_d;
                co_q <= c_ch[DIGIT];
                ov_q <= c_ch[DIGIT-1] ^ c_ch[DIGIT];
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign So   = so_q;
    assign Co   = co_q;
    assign Ov   = ov_q;

endmodule
